// File: rtl/vip_job_sched.sv
// vip_job_sched
//   Runs one VIP vector-inner-product core over a batch of jobs. Job n reads
//   its operands from memory bank n (1024 words per bank). For each job the
//   scheduler:
//     - pulses the VIP reset,
//     - holds VipStart while the VIP runs,
//     - adds the VIP's signed result into a running sum.
//   A job that runs past TIMEOUT cycles aborts the whole batch with Error set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   Start, NumJobs      host batch request; NumJobs is the job count minus one
//   Busy, Done, Error   batch status; Error is meaningful while Done is high
//   JobIdx              current job index, or the last one run
//   SumResult           signed sum of the results of completed jobs
//   MemAddr/MemEn/MemData   shared data memory port (read data is combinational)
//   VipRst_n/VipStart       registered VIP control
//   VipAddr/VipEn/VipData   VIP local memory port, mapped into the job's bank
//   VipResult/VipFinish     VIP result and level completion flag
module vip_job_sched #(
  parameter int dataWidth = 32,
  parameter int memWidth  = 10,
  parameter int bankWidth = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           Start,
  input  logic [bankWidth-1:0]           NumJobs,
  output logic                           Busy,
  output logic                           Done,
  output logic                           Error,
  output logic [bankWidth-1:0]           JobIdx,
  output logic [dataWidth+bankWidth-1:0] SumResult,
  output logic [bankWidth+memWidth-1:0]  MemAddr,
  output logic                           MemEn,
  input  logic [dataWidth-1:0]           MemData,
  output logic                           VipRst_n,
  output logic                           VipStart,
  input  logic [memWidth-1:0]            VipAddr,
  input  logic                           VipEn,
  output logic [dataWidth-1:0]           VipData,
  input  logic [dataWidth-1:0]           VipResult,
  input  logic                           VipFinish
);

  localparam int timerWidth = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RST, RUN, CAP, FIN} state_t;

  state_t                 state;
  logic [bankWidth-1:0]   last_job;
  logic [dataWidth-1:0]   last_result;
  logic [1:0]             rst_cnt;
  logic [timerWidth-1:0]  timer;

  // The VIP's local address space is placed inside the bank of the current job.
  // Memory reads are only let through while the VIP is actually running.
  assign MemAddr = {JobIdx, VipAddr};
  assign MemEn   = VipEn & (state == RUN);
  assign VipData = MemEn ? MemData : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      JobIdx      <= '0;
      SumResult   <= '0;
      VipRst_n    <= 1'b0;
      VipStart    <= 1'b0;
      last_job    <= '0;
      last_result <= '0;
      rst_cnt     <= '0;
      timer       <= '0;
    end else begin
      case (state)
        // IDLE and FIN both accept a new batch. Done and Error from the
        // previous batch stay visible until that happens.
        IDLE, FIN: begin
          if (Start) begin
            last_job  <= NumJobs;
            JobIdx    <= '0;
            SumResult <= '0;
            Error     <= 1'b0;
            Done      <= 1'b0;
            Busy      <= 1'b1;
            rst_cnt   <= '0;
            state     <= RST;
          end
        end

        // Hold the VIP in reset for two cycles, then release it and start it.
        RST: begin
          if (rst_cnt == 2'd1) begin
            VipRst_n <= 1'b1;
            VipStart <= 1'b1;
            timer    <= '0;
            state    <= RUN;
          end else begin
            rst_cnt <= rst_cnt + 2'd1;
          end
        end

        // If VipFinish arrives on the last allowed cycle, the job completes;
        // completion takes priority over the timeout.
        RUN: begin
          if (VipFinish) begin
            last_result <= VipResult;
            VipRst_n    <= 1'b0;
            VipStart    <= 1'b0;
            state       <= CAP;
          end else if (timer == timerWidth'(TIMEOUT - 1)) begin
            Error    <= 1'b1;
            Done     <= 1'b1;
            Busy     <= 1'b0;
            VipRst_n <= 1'b0;
            VipStart <= 1'b0;
            state    <= FIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Accumulate the sign-extended result. The sum is bankWidth bits
        // wider than a result, so a full batch of results cannot overflow it.
        CAP: begin
          SumResult <= SumResult +
                       {{bankWidth{last_result[dataWidth-1]}}, last_result};
          if (JobIdx == last_job) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= FIN;
          end else begin
            JobIdx  <= JobIdx + 1'b1;
            rst_cnt <= '0;
            state   <= RST;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vip_job_sched.sv
module tb_vip_job_sched;

  localparam int TB_TIMEOUT = 1100;
  localparam int DONE_BOUND = 5000;

  typedef struct {
    logic [33:0] sum;
    logic [1:0]  idx;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [1:0]  NumJobs;
  logic        Busy, Done, Error;
  logic [1:0]  JobIdx;
  logic [33:0] SumResult;
  logic [11:0] MemAddr;
  logic        MemEn;
  logic [31:0] MemData;
  logic        VipRst_n, VipStart;
  logic [9:0]  VipAddr;
  logic        VipEn;
  logic [31:0] VipData;
  logic [31:0] VipResult;
  logic        VipFinish;

  int checks = 0;
  int errors = 0;

  // Scoreboards: expected bank per job start, expected batch outcome per Done.
  int   bank_q[$];
  exp_t res_q[$];

  // VIP and memory model
  int          job_k[4];     // RUN cycles until finish; 0 = never finishes
  logic [31:0] job_res[4];
  int          run_cnt = 0;

  always #5 clk = ~clk;

  vip_job_sched #(
    .dataWidth(32), .memWidth(10), .bankWidth(2), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .NumJobs(NumJobs),
    .Busy(Busy), .Done(Done), .Error(Error), .JobIdx(JobIdx),
    .SumResult(SumResult), .MemAddr(MemAddr), .MemEn(MemEn),
    .MemData(MemData), .VipRst_n(VipRst_n), .VipStart(VipStart),
    .VipAddr(VipAddr), .VipEn(VipEn), .VipData(VipData),
    .VipResult(VipResult), .VipFinish(VipFinish)
  );

  always @(posedge clk) begin
    if (VipRst_n && VipStart) run_cnt <= run_cnt + 1;
    else                      run_cnt <= 0;
  end

  assign MemData   = 32'hA5A5_0000 | {20'h0, MemAddr};
  assign VipAddr   = 10'(run_cnt);
  assign VipEn     = ~run_cnt[0];  // also high outside RUN, so gating is exercised
  assign VipResult = job_res[JobIdx];
  assign VipFinish = VipRst_n && VipStart && (job_k[JobIdx] != 0) &&
                     (run_cnt == job_k[JobIdx] - 1);

  // Monitor: data path every cycle, bank on each job start, batch outcome on Done
  bit          prev_vs = 0, prev_busy = 0, prev_done = 0;
  int          low_cnt = 0, jobs_seen = 0, cyc = 0;
  logic        exp_men;
  logic [11:0] exp_addr;
  logic [31:0] exp_vd;
  int          exp_bank;
  exp_t        e;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_addr = {JobIdx, VipAddr};
      exp_men  = VipEn & VipStart;
      exp_vd   = exp_men ? (32'hA5A5_0000 | {20'h0, exp_addr}) : 32'h0;
      checks++;
      if (MemAddr !== exp_addr || MemEn !== exp_men || VipData !== exp_vd) begin
        errors++;
        $display("FAIL datapath: got addr=%h en=%b data=%h expected addr=%h en=%b data=%h",
                 MemAddr, MemEn, VipData, exp_addr, exp_men, exp_vd);
      end
      if (VipStart && !prev_vs) begin
        checks++;
        if (bank_q.size() == 0) begin
          errors++;
          $display("FAIL job_start: got unexpected start bank=%0d expected none", MemAddr[11:10]);
        end else begin
          exp_bank = bank_q.pop_front();
          if (32'(MemAddr[11:10]) != exp_bank) begin
            errors++;
            $display("FAIL bank: got %0d expected %0d", MemAddr[11:10], exp_bank);
          end
        end
        // Between jobs VipRst_n is low for the CAP cycle plus 2 RST cycles.
        if (jobs_seen > 0) begin
          checks++;
          if (low_cnt != 3) begin
            errors++;
            $display("FAIL vip_rst_gap: got %0d expected 3", low_cnt);
          end
        end
        jobs_seen++;
        $display("job start: bank=%0d", MemAddr[11:10]);
      end
      if (Busy && !prev_busy)             cyc = 1;
      else if (Busy || (Done && !prev_done)) cyc++;
      if (Done && !prev_done) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL done: got unexpected Done expected none");
        end else begin
          e = res_q.pop_front();
          if (SumResult !== e.sum || JobIdx !== e.idx || Error !== e.err || cyc != e.cyc) begin
            errors++;
            $display("FAIL batch: got sum=%h idx=%0d err=%b cyc=%0d expected sum=%h idx=%0d err=%b cyc=%0d",
                     SumResult, JobIdx, Error, cyc, e.sum, e.idx, e.err, e.cyc);
          end
        end
        $display("batch done: sum=%h idx=%0d err=%b cycles=%0d", SumResult, JobIdx, Error, cyc);
      end
      low_cnt = VipRst_n ? 0 : low_cnt + 1;
    end
    prev_vs   = VipStart;
    prev_busy = Busy;
    prev_done = Done;
  end

  // Stimulus helpers (no comparisons of DUT values against expectations here)
  task automatic start_batch(input logic [1:0] nj);
    @(negedge clk);
    jobs_seen = 0;
    Start     = 1'b1;
    NumJobs   = nj;
    @(negedge clk);
    Start     = 1'b0;
    NumJobs   = 2'd0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < DONE_BOUND; i++) begin
      @(negedge clk);
      if (Done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got Done=0 expected Done=1 within %0d cycles", DONE_BOUND);
    end
    @(negedge clk);
  endtask

  task automatic wait_vipstart();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (VipStart) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL vipstart_timeout: got VipStart=0 expected VipStart=1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b0; NumJobs = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Busy, Done, Error, JobIdx, VipRst_n, VipStart, MemEn} !== 8'b0 ||
        SumResult !== 34'h0 || VipData !== 32'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b err=%b idx=%0d sum=%h vrst=%b vst=%b men=%b vdata=%h expected all 0",
               Busy, Done, Error, JobIdx, SumResult, VipRst_n, VipStart, MemEn, VipData);
    end
    $display("reset checked");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_job();
    job_k[0] = 1030; job_res[0] = -32'sd5;
    bank_q.push_back(0);
    res_q.push_back('{sum: -34'sd5, idx: 2'd0, err: 1'b0, cyc: 2 + 1030 + 1 + 1});
    start_batch(2'd0);
    // now just after E0
    checks++;
    if (Busy !== 1'b1 || VipRst_n !== 1'b0 || VipStart !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL start_e0: got busy=%b vrst=%b vst=%b done=%b expected 1 0 0 0", Busy, VipRst_n, VipStart, Done);
    end
    @(negedge clk);
    checks++;
    if (VipRst_n !== 1'b0 || VipStart !== 1'b0) begin
      errors++;
      $display("FAIL start_e1: got vrst=%b vst=%b expected 0 0", VipRst_n, VipStart);
    end
    @(negedge clk);
    checks++;
    if (VipRst_n !== 1'b1 || VipStart !== 1'b1) begin
      errors++;
      $display("FAIL start_e2: got vrst=%b vst=%b expected 1 1", VipRst_n, VipStart);
    end
    wait_done();
  endtask

  task automatic test_three_jobs();
    job_k[0] = 5; job_res[0] = 32'sd100;
    job_k[1] = 8; job_res[1] = -32'sd300;
    job_k[2] = 3; job_res[2] = 32'sd7;
    for (int i = 0; i < 3; i++) bank_q.push_back(i);
    res_q.push_back('{sum: -34'sd193, idx: 2'd2, err: 1'b0, cyc: 8 + 11 + 6 + 1});
    start_batch(2'd2);
    wait_done();
  endtask

  task automatic test_width();
    for (int i = 0; i < 4; i++) begin
      job_k[i] = 3; job_res[i] = 32'h8000_0000; bank_q.push_back(i);
    end
    res_q.push_back('{sum: 34'h2_0000_0000, idx: 2'd3, err: 1'b0, cyc: 4 * 6 + 1});
    start_batch(2'd3);
    wait_done();
  endtask

  task automatic test_timeout();
    job_k[0] = 4; job_res[0] = 32'sd9;
    job_k[1] = 0; job_res[1] = 32'sd1000;
    bank_q.push_back(0); bank_q.push_back(1);
    res_q.push_back('{sum: 34'sd9, idx: 2'd1, err: 1'b1, cyc: 7 + 2 + TB_TIMEOUT + 1});
    start_batch(2'd2);
    wait_done();
  endtask

  task automatic test_finish_at_limit();
    job_k[0] = TB_TIMEOUT; job_res[0] = -32'sd16;
    bank_q.push_back(0);
    res_q.push_back('{sum: -34'sd16, idx: 2'd0, err: 1'b0, cyc: 2 + TB_TIMEOUT + 1 + 1});
    start_batch(2'd0);
    wait_done();
  endtask

  task automatic test_start_ignored();
    job_k[0] = 40; job_res[0] = 32'sd11;
    job_k[1] = 6;  job_res[1] = -32'sd2;
    bank_q.push_back(0); bank_q.push_back(1);
    res_q.push_back('{sum: 34'sd9, idx: 2'd1, err: 1'b0, cyc: 43 + 9 + 1});
    start_batch(2'd1);
    wait_vipstart();
    repeat (5) @(negedge clk);
    Start = 1'b1; NumJobs = 2'd3;
    @(negedge clk);
    Start = 1'b0; NumJobs = 2'd0;
    checks++;
    if (Busy !== 1'b1 || JobIdx !== 2'd0 || VipStart !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: got busy=%b idx=%0d vst=%b expected 1 0 1", Busy, JobIdx, VipStart);
    end
    wait_done();
  endtask

  task automatic test_reset_mid_run();
    job_k[0] = 50; job_res[0] = 32'sd77;
    job_k[1] = 50; job_res[1] = 32'sd77;
    bank_q.push_back(0);
    start_batch(2'd1);
    wait_vipstart();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Error, JobIdx, VipRst_n, VipStart, MemEn} !== 8'b0 ||
        SumResult !== 34'h0 || VipData !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b err=%b idx=%0d sum=%h vrst=%b vst=%b men=%b vdata=%h expected all 0",
               Busy, Done, Error, JobIdx, SumResult, VipRst_n, VipStart, MemEn, VipData);
    end
    $display("reset mid-run checked");
    bank_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    job_k[0] = 5; job_res[0] = -32'sd1;
    bank_q.push_back(0);
    res_q.push_back('{sum: -34'sd1, idx: 2'd0, err: 1'b0, cyc: 2 + 5 + 1 + 1});
    start_batch(2'd0);
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin job_k[i] = 0; job_res[i] = '0; end
    test_reset();
    test_single_job();
    test_three_jobs();
    test_width();
    test_timeout();
    test_finish_at_limit();
    test_start_ignored();
    test_reset_mid_run();
    checks++;
    if (bank_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d banks %0d batches left expected 0 0", bank_q.size(), res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
